// File: rtl/neuron_level_argmax_if.sv
// Stream-in / result-out bundle for neuron_level_argmax.
// master: the side that supplies neuron values and consumes results (testbench/upstream).
// slave:  the argmax block itself.
interface neuron_level_argmax_if #(
  parameter int INT_WIDTH = 4,
  parameter int IDX_WIDTH = 2
);
  logic                 in_valid;
  logic                 in_ready;
  logic [INT_WIDTH-1:0] in_data;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [IDX_WIDTH-1:0] out_index;
  logic [INT_WIDTH-1:0] out_value;
  logic                 out_len_err;
  logic                 out_confident;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_index, out_value, out_len_err, out_confident
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_index, out_value, out_len_err, out_confident
  );
endinterface

// File: rtl/neuron_level_argmax.sv
// neuron_level_argmax: per-frame argmax over a serial stream of neuron outputs.
// A frame closes on in_last or after COUNT values, whichever comes first; the
// result is held until the consumer takes it. Ties keep the lowest index.
// Optional feature: define NEURON_ARGMAX_THRESHOLD_EN to grade each result
// against THRESHOLD; otherwise every result is reported confident.
module neuron_level_argmax #(
  parameter int INT_WIDTH = 4,
  parameter int COUNT     = 4,
  parameter int IDX_WIDTH = 2,
  parameter int THRESHOLD = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  neuron_level_argmax_if.slave  bus
);

  typedef enum logic {ACCUM, HOLD} state_t;

  localparam logic [IDX_WIDTH:0] LAST_POS = (IDX_WIDTH+1)'(COUNT - 1);

  state_t               state_q, state_d;
  logic [IDX_WIDTH:0]   pos_q, pos_d;
  logic [INT_WIDTH-1:0] max_val_q, max_val_d;
  logic [IDX_WIDTH-1:0] max_idx_q, max_idx_d;
  logic                 len_err_q, len_err_d;
`ifdef NEURON_ARGMAX_THRESHOLD_EN
  localparam logic [INT_WIDTH-1:0] THR = INT_WIDTH'(THRESHOLD);
  logic                 confident_q, confident_d;
`endif

  logic accept;
  logic at_end;
  logic closing;

  assign accept  = (state_q == ACCUM) && bus.in_valid;
  assign at_end  = (pos_q == LAST_POS);
  assign closing = accept && (bus.in_last || at_end);

  // Next-state and datapath update for both FSM states.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned and infers a latch.
    state_d   = state_q;
    pos_d     = pos_q;
    max_val_d = max_val_q;
    max_idx_d = max_idx_q;
    len_err_d = len_err_q;
`ifdef NEURON_ARGMAX_THRESHOLD_EN
    confident_d = confident_q;
`endif
    unique case (state_q)
      ACCUM: begin
        if (accept) begin
          // First value of a frame always seeds the max; later ones must be strictly larger.
          if ((pos_q == '0) || (bus.in_data > max_val_q)) begin
            max_val_d = bus.in_data;
            max_idx_d = pos_q[IDX_WIDTH-1:0];
          end
          if (closing) begin
            len_err_d = bus.in_last ^ at_end;
            pos_d     = '0;
            state_d   = HOLD;
`ifdef NEURON_ARGMAX_THRESHOLD_EN
            confident_d = (max_val_d >= THR);
`endif
          end else begin
            pos_d = pos_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (bus.out_ready) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  // State and result registers; reset discards any partial frame or pending result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ACCUM;
      pos_q     <= '0;
      max_val_q <= '0;
      max_idx_q <= '0;
      len_err_q <= 1'b0;
`ifdef NEURON_ARGMAX_THRESHOLD_EN
      confident_q <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q   <= state_d;
      pos_q     <= pos_d;
      max_val_q <= max_val_d;
      max_idx_q <= max_idx_d;
      len_err_q <= len_err_d;
`ifdef NEURON_ARGMAX_THRESHOLD_EN
      confident_q <= confident_d;
`endif
    end
  end

  // Outputs come straight from registers: no combinational path from inputs.
  assign bus.in_ready    = (state_q == ACCUM);
  assign bus.out_valid   = (state_q == HOLD);
  assign bus.out_index   = max_idx_q;
  assign bus.out_value   = max_val_q;
  assign bus.out_len_err = len_err_q;
`ifdef NEURON_ARGMAX_THRESHOLD_EN
  assign bus.out_confident = confident_q && (state_q == HOLD);
`else
  assign bus.out_confident = (state_q == HOLD);
`endif

endmodule

// File: tb/tb_neuron_level_argmax.sv
// Self-checking bench for neuron_level_argmax: directed frames from the test
// plan followed by randomized frames, all checked against a frame-level model.
module tb_neuron_level_argmax;
  localparam int INT_WIDTH = 4;
  localparam int COUNT     = 4;
  localparam int IDX_WIDTH = 2;
  localparam int THRESHOLD = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  neuron_level_argmax_if #(.INT_WIDTH(INT_WIDTH), .IDX_WIDTH(IDX_WIDTH)) bus ();

  neuron_level_argmax #(
    .INT_WIDTH(INT_WIDTH), .COUNT(COUNT), .IDX_WIDTH(IDX_WIDTH), .THRESHOLD(THRESHOLD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int vals [8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int exp_conf(input int mx);
`ifdef NEURON_ARGMAX_THRESHOLD_EN
    return (mx >= THRESHOLD) ? 1 : 0;
`else
    return 1;
`endif
  endfunction

  // Offer one value starting at a negedge; returns at the negedge after the handshake.
  task automatic send(input int d, input bit last, output bit ok);
    logic rdy;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = INT_WIDTH'(d);
    bus.in_last  = last;
    for (int t = 0; t < 20; t++) begin
      rdy = bus.in_ready;
      @(posedge clk);
      if (rdy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Send vals[0..n-1] (in_last on index last_at, -1 = never), check the result,
  // hold it hold_cyc cycles with junk offered upstream, then release it.
  task automatic run_frame(input string name, input int n, input int last_at,
                           input int gap_max, input int hold_cyc);
    int  m = 0;
    bit  by_last = 1'b0;
    bit  ok;
    int  mx, mi, le;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, gap_max)) @(negedge clk);
      send(vals[i], (i == last_at), ok);
      check({name, ".hs"}, ok, 1);
      m++;
      if (i == last_at) begin
        by_last = 1'b1;
        break;
      end
      if (m == COUNT) break;
    end
    // Reference: first occurrence of the maximum over received values.
    mx = vals[0];
    mi = 0;
    for (int j = 1; j < m; j++)
      if (vals[j] > mx) begin
        mx = vals[j];
        mi = j;
      end
    le = (by_last && m == COUNT) ? 0 : 1;

    check({name, ".out_valid"}, bus.out_valid, 1);
    check({name, ".in_ready"},  bus.in_ready, 0);
    check({name, ".index"},     bus.out_index, mi);
    check({name, ".value"},     bus.out_value, mx);
    check({name, ".len_err"},   bus.out_len_err, le);
    check({name, ".conf"},      bus.out_confident, exp_conf(mx));

    if (hold_cyc > 0) begin
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = INT_WIDTH'($urandom);
      bus.in_last   = 1'($urandom);
      repeat (hold_cyc) begin
        @(negedge clk);
        check({name, ".hold_valid"}, bus.out_valid, 1);
        check({name, ".hold_ready"}, bus.in_ready, 0);
        check({name, ".hold_index"}, bus.out_index, mi);
        check({name, ".hold_value"}, bus.out_value, mx);
      end
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check({name, ".released_valid"}, bus.out_valid, 0);
    check({name, ".released_ready"}, bus.in_ready, 1);
    bus.out_ready = 1'($urandom_range(0, 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    bit ok;
    int n, la;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.in_ready",  bus.in_ready, 1);
    check("rst.out_valid", bus.out_valid, 0);
    check("rst.index",     bus.out_index, 0);
    check("rst.value",     bus.out_value, 0);
    check("rst.len_err",   bus.out_len_err, 0);
    check("rst.conf",      bus.out_confident, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic frame, consumer always ready.
    bus.out_ready = 1'b1;
    vals[0] = 3; vals[1] = 9; vals[2] = 5; vals[3] = 2;
    run_frame("basic", 4, 3, 0, 0);

    // Ties keep the lowest index.
    vals[0] = 7; vals[1] = 7; vals[2] = 15; vals[3] = 15;
    run_frame("tie", 4, 3, 0, 0);
    vals[0] = 0; vals[1] = 0; vals[2] = 0; vals[3] = 0;
    run_frame("zeros", 4, 3, 0, 0);

    // Early last, then a well-formed frame.
    vals[0] = 4; vals[1] = 12;
    run_frame("early", 2, 1, 0, 0);
    vals[0] = 1; vals[1] = 2; vals[2] = 3; vals[3] = 4;
    run_frame("after_early", 4, 3, 0, 0);

    // Missing last.
    vals[0] = 6; vals[1] = 1; vals[2] = 1; vals[3] = 1;
    run_frame("no_last", 4, -1, 0, 0);

    // Gaps and backpressure.
    vals[0] = 10; vals[1] = 3; vals[2] = 11; vals[3] = 0;
    run_frame("backpressure", 4, 3, 3, 5);

    // Reset partway through a frame.
    bus.out_ready = 1'b0;
    send(5, 1'b0, ok);
    check("mid.hs0", ok, 1);
    send(14, 1'b0, ok);
    check("mid.hs1", ok, 1);
    rst_n = 1'b0;
    #1;
    check("mid.rst_ready", bus.in_ready, 1);
    check("mid.rst_valid", bus.out_valid, 0);
    check("mid.rst_value", bus.out_value, 0);
    check("mid.rst_index", bus.out_index, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vals[0] = 2; vals[1] = 8; vals[2] = 3; vals[3] = 1;
    run_frame("post_rst", 4, 3, 0, 0);

    // Randomized frames.
    for (int f = 0; f < 40; f++) begin
      n = $urandom_range(1, COUNT);
      if (n < COUNT) la = n - 1;
      else la = ($urandom_range(0, 1) != 0) ? COUNT - 1 : -1;
      for (int k = 0; k < COUNT; k++) vals[k] = $urandom_range(0, (1 << INT_WIDTH) - 1);
      run_frame("rand", n, la, 2, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
